// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer controllers.
// Holds the Gray/binary conversion helpers, default sizing constants and
// the default pointer type used by both the write-side and read-side logic.
package fifo_pkg;

    // Default geometry: depth 16, two-flop read-pointer synchronizer.
    localparam int ADDR_W_DEF      = 4;
    localparam int SYNC_STAGES_DEF = 2;

    // Working width of the conversion helpers; callers pass the live width
    // and truncate the result back to their own pointer size.
    localparam int FN_W = 32;

    typedef logic [ADDR_W_DEF:0] ptr_t;
    typedef logic [FN_W-1:0]     fn_word_t;

    // Binary to Gray for the low w bits of b; bits at and above w are zero.
    function automatic fn_word_t bin2gray(input fn_word_t b, input int w);
        fn_word_t bm;
        fn_word_t t;
        fn_word_t g;
        bm = '0;
        for (int i = 0; i < FN_W; i++) begin
            if (i < w) begin
                bm[i] = b[i];
            end
        end
        t = bm ^ (bm >> 1);
        g = '0;
        for (int i = 0; i < FN_W; i++) begin
            if (i < w) begin
                g[i] = t[i];
            end
        end
        return g;
    endfunction

    // Gray to binary for the low w bits of g: each binary bit is the XOR of
    // all Gray bits at and above it.
    function automatic fn_word_t gray2bin(input fn_word_t g, input int w);
        fn_word_t gm;
        fn_word_t b;
        gm = '0;
        for (int i = 0; i < FN_W; i++) begin
            if (i < w) begin
                gm[i] = g[i];
            end
        end
        b = '0;
        for (int i = 0; i < FN_W; i++) begin
            if (i < w) begin
                b[i] = ^(gm >> i);
            end
        end
        return b;
    endfunction

endpackage : fifo_pkg

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
// STAGES flops deep, N bits wide, every stage clears to zero on the
// asynchronous active-high reset. Shared by the write and read controllers.
module sync_chain #(
    parameter int N      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] stage_reg [STAGES];

    // First stage samples the asynchronous input directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg[0] <= '0;
        end else begin
            stage_reg[0] <= d;
        end
    end

    // Remaining stages give the first flop time to resolve metastability.
    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
            // Shift the previous stage forward by one clock.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_reg[gi] <= '0;
                end else begin
                    stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule : sync_chain

// File: rtl/fifo_wptr_full_ctrl.sv
// Write-side pointer and full-flag controller for the async FIFO.
// Runs entirely in the write clock domain: gates write requests, steps the
// binary/Gray write pointers, synchronizes the read pointer, and derives
// full, occupancy and a sticky overflow flag.
// Optional build macro FIFO_ALMOST_FULL_EN adds a registered almost-full
// flag; without it afull is tied low and no comparator is built.
module fifo_wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
`ifdef FIFO_ALMOST_FULL_EN
    ,
    parameter int AFULL_THRESH = 12
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              winc,
    input  logic              ovf_clr,
    input  logic [ADDR_W:0]   rptr_gray_async,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic [ADDR_W:0]   wcount,
    output logic              overflow,
    output logic              afull
);

    localparam int PW = ADDR_W + 1;

    logic [ADDR_W:0] wbin_reg;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wptr_gray_reg;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rq_gray;
    logic [ADDR_W:0] rbin_sync;
    logic [ADDR_W:0] full_match;
    logic            full_reg;
    logic            full_next;
    logic            overflow_reg;
    logic            overflow_next;

    // Bring the read domain's Gray pointer into this clock domain.
    sync_chain #(
        .N      (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk (clk),
        .rst (rst),
        .d   (rptr_gray_async),
        .q   (rq_gray)
    );

    assign rbin_sync = PW'(gray2bin(FN_W'(rq_gray), PW));

    // Accept a write only when not full; reset kills a pending write at once.
    always_comb begin
        wen = winc & ~full_reg & ~rst;
    end

    // Pointer value after this edge, in binary and Gray.
    always_comb begin
        wbin_next  = wbin_reg + PW'(wen);
        wgray_next = PW'(bin2gray(FN_W'(wbin_next), PW));
    end

    // Full when the next write pointer laps the synced read pointer: Gray
    // codes differ only in the top two bits, which are inverted.
    always_comb begin
        full_match = {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]};
        full_next  = (wgray_next == full_match);
    end

    // Sticky overflow: a rejected write sets it and beats a same-cycle clear.
    always_comb begin
        overflow_next = overflow_reg;
        if (winc && full_reg) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    // Write pointers advance together on every accepted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin_reg      <= '0;
            wptr_gray_reg <= '0;
        end else begin
            wbin_reg      <= wbin_next;
            wptr_gray_reg <= wgray_next;
        end
    end

    // Full and overflow flags are registered every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            full_reg     <= full_next;
            overflow_reg <= overflow_next;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_W:0] AFULL_T = PW'(AFULL_THRESH);

    logic [ADDR_W:0] afull_occ;
    logic            afull_reg;

    // Occupancy the FIFO will have after this edge, seen through the
    // delayed read pointer, so the flag is late to clear but never early.
    always_comb begin
        afull_occ = wbin_next - rbin_sync;
    end

    // Almost-full is registered alongside full with the same latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            afull_reg <= 1'b0;
        end else begin
            afull_reg <= (afull_occ >= AFULL_T);
        end
    end

    assign afull = afull_reg;
`else
    assign afull = 1'b0;
`endif

    assign waddr     = wbin_reg[ADDR_W-1:0];
    assign wptr_gray = wptr_gray_reg;
    assign full      = full_reg;
    assign overflow  = overflow_reg;
    // Modulo subtraction keeps the count right across pointer wrap.
    assign wcount    = wbin_reg - rbin_sync;

endmodule : fifo_wptr_full_ctrl

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Self-checking bench for the async FIFO write-side controller.
// Expected write addresses go into a scoreboard queue when a write is
// driven and are popped when the DUT asserts wen.
module tb_fifo_wptr_full_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       winc;
    logic       ovf_clr;
    logic [4:0] rptr_gray_async;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr_gray;
    logic       full;
    logic [4:0] wcount;
    logic       overflow;
    logic       afull;

    int checks   = 0;
    int failures = 0;

    logic [3:0] addr_q [$];

    fifo_wptr_full_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .winc            (winc),
        .ovf_clr         (ovf_clr),
        .rptr_gray_async (rptr_gray_async),
        .wen             (wen),
        .waddr           (waddr),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .wcount          (wcount),
        .overflow        (overflow),
        .afull           (afull)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] g_of(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Advance one rising edge and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        winc = 1'b0;
        ovf_clr = 1'b0;
        rptr_gray_async = 5'd0;
        step();
        step();
        rst = 1'b0;
        step();
        addr_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        winc = 1'b1;
        step();
        step();
        step();
        // Assert reset between edges and check without any clock edge.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (wptr_gray !== 5'd0) begin
            failures++;
            $display("FAIL reset_wptr_gray got=%0h exp=0", wptr_gray);
        end
        checks++;
        if (full !== 1'b0) begin
            failures++;
            $display("FAIL reset_full got=%0b exp=0", full);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_overflow got=%0b exp=0", overflow);
        end
        checks++;
        if (wcount !== 5'd0) begin
            failures++;
            $display("FAIL reset_wcount got=%0d exp=0", wcount);
        end
        checks++;
        if (wen !== 1'b0 || waddr !== 4'd0) begin
            failures++;
            $display("FAIL reset_wen_waddr got=%0b/%0h exp=0/0", wen, waddr);
        end
        checks++;
        if (afull !== 1'b0) begin
            failures++;
            $display("FAIL reset_afull got=%0b exp=0", afull);
        end
        @(negedge clk);
        winc = 1'b0;
        rst = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_fill();
        logic [4:0] prev;
        logic [3:0] exp_a;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            winc = 1'b1;
            addr_q.push_back(4'(i));
            #1;
            checks++;
            if (wen !== 1'b1) begin
                failures++;
                $display("FAIL fill_wen[%0d] got=%0b exp=1", i, wen);
            end else begin
                exp_a = addr_q.pop_front();
                checks++;
                if (waddr !== exp_a) begin
                    failures++;
                    $display("FAIL fill_waddr[%0d] got=%0d exp=%0d", i, waddr, exp_a);
                end
            end
            prev = wptr_gray;
            step();
            checks++;
            if ($countones(prev ^ wptr_gray) != 1) begin
                failures++;
                $display("FAIL fill_gray_step[%0d] got=%05b exp_one_flip_from=%05b", i, wptr_gray, prev);
            end
            checks++;
            if (full !== (i == 15)) begin
                failures++;
                $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, full, (i == 15));
            end
            $display("fill write %0d wptr_gray=%05b full=%0b", i, wptr_gray, full);
        end
        winc = 1'b0;
        checks++;
        if (wptr_gray !== 5'b11000) begin
            failures++;
            $display("FAIL fill_wptr_gray got=%05b exp=11000", wptr_gray);
        end
        checks++;
        if (wcount !== 5'd16) begin
            failures++;
            $display("FAIL fill_wcount got=%0d exp=16", wcount);
        end
`ifndef FIFO_ALMOST_FULL_EN
        checks++;
        if (afull !== 1'b0) begin
            failures++;
            $display("FAIL fill_afull_off got=%0b exp=0", afull);
        end
`endif
    endtask

    task automatic test_overflow();
        logic [4:0] g0;
        winc = 1'b1;
        #1;
        checks++;
        if (wen !== 1'b0) begin
            failures++;
            $display("FAIL ovf_wen got=%0b exp=0", wen);
        end
        g0 = wptr_gray;
        step();
        winc = 1'b0;
        checks++;
        if (wptr_gray !== 5'b11000) begin
            failures++;
            $display("FAIL ovf_wptr_hold got=%05b exp=%05b", wptr_gray, g0);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got=%0b exp=1", overflow);
        end
        step();
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_held got=%0b exp=1", overflow);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%0b exp=0", overflow);
        end
        ovf_clr = 1'b1;
        winc = 1'b1;
        step();
        ovf_clr = 1'b0;
        winc = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins got=%0b exp=1", overflow);
        end
        $display("test_overflow done overflow=%0b", overflow);
    endtask

    task automatic test_read_release();
        rptr_gray_async = 5'b00001;
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (full !== (e < 3)) begin
                failures++;
                $display("FAIL release_full_edge%0d got=%0b exp=%0b", e, full, (e < 3));
            end
        end
        checks++;
        if (wcount !== 5'd15) begin
            failures++;
            $display("FAIL release_wcount got=%0d exp=15", wcount);
        end
        $display("test_read_release done full=%0b wcount=%0d", full, wcount);
    endtask

    task automatic test_wrap();
        logic [4:0] wbin_m, rbin_m, s1, s2, nxt, prev;
        logic       full_m, exp_wen, wrapped;
        logic [3:0] exp_a;
        int         writes, cyc;
        do_reset();
        wbin_m = 0; rbin_m = 0; s1 = 0; s2 = 0;
        full_m = 1'b0; wrapped = 1'b0;
        writes = 0; cyc = 0;
        while (writes < 40 && cyc < 300) begin
            cyc++;
            winc = 1'b1;
            if ((cyc % 3) != 0 && rbin_m != wbin_m) begin
                rbin_m = rbin_m + 5'd1;
            end
            rptr_gray_async = g_of(rbin_m);
            exp_wen = ~full_m;
            #1;
            checks++;
            if (full !== full_m) begin
                failures++;
                $display("FAIL wrap_full[%0d] got=%0b exp=%0b", cyc, full, full_m);
            end
            checks++;
            if (wen !== exp_wen) begin
                failures++;
                $display("FAIL wrap_wen[%0d] got=%0b exp=%0b", cyc, wen, exp_wen);
            end
            checks++;
            if (wcount !== 5'(wbin_m - s2)) begin
                failures++;
                $display("FAIL wrap_wcount[%0d] got=%0d exp=%0d", cyc, wcount, 5'(wbin_m - s2));
            end
            if (exp_wen) begin
                addr_q.push_back(wbin_m[3:0]);
            end
            if (wen && addr_q.size() > 0) begin
                exp_a = addr_q.pop_front();
                checks++;
                if (waddr !== exp_a) begin
                    failures++;
                    $display("FAIL wrap_waddr[%0d] got=%0d exp=%0d", cyc, waddr, exp_a);
                end
            end
            prev = wptr_gray;
            nxt = wbin_m + 5'(exp_wen);
            full_m = (5'(nxt - s2) == 5'd16);
            s2 = s1;
            s1 = rbin_m;
            if (exp_wen && nxt == 5'd0) begin
                wrapped = 1'b1;
            end
            wbin_m = nxt;
            if (exp_wen) begin
                writes++;
            end
            step();
            if (exp_wen) begin
                checks++;
                if ($countones(prev ^ wptr_gray) != 1) begin
                    failures++;
                    $display("FAIL wrap_gray_step[%0d] got=%05b prev=%05b", cyc, wptr_gray, prev);
                end
            end
            $display("wrap cyc %0d wen=%0b wptr_gray=%05b rbin=%0d wcount=%0d full=%0b",
                     cyc, exp_wen, wptr_gray, rbin_m, wcount, full);
        end
        winc = 1'b0;
        checks++;
        if (writes != 40) begin
            failures++;
            $display("FAIL wrap_write_budget got=%0d exp=40", writes);
        end
        checks++;
        if (wrapped !== 1'b1) begin
            failures++;
            $display("FAIL wrap_seen got=%0b exp=1", wrapped);
        end
    endtask

`ifdef FIFO_ALMOST_FULL_EN
    task automatic test_afull();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            winc = 1'b1;
            step();
            checks++;
            if (afull !== (i == 11)) begin
                failures++;
                $display("FAIL afull_write[%0d] got=%0b exp=%0b", i, afull, (i == 11));
            end
        end
        winc = 1'b0;
        rptr_gray_async = 5'b00001;
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if (afull !== (e < 3)) begin
                failures++;
                $display("FAIL afull_release_edge%0d got=%0b exp=%0b", e, afull, (e < 3));
            end
        end
        $display("test_afull done afull=%0b", afull);
    endtask
`endif

    initial begin
        rst = 1'b1;
        winc = 1'b0;
        ovf_clr = 1'b0;
        rptr_gray_async = 5'd0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_overflow();
        test_read_release();
        test_wrap();
`ifdef FIFO_ALMOST_FULL_EN
        test_afull();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fifo_wptr_full_ctrl

// File: doc/fifo_wptr_full_ctrl.md
Name: fifo_wptr_full_ctrl

Overview:
Write-side controller for the async FIFO, running entirely in the write clock domain.
- Gates write requests into memory write enables and drives the memory write address.
- Maintains binary and Gray write pointers; publishes the Gray write pointer for the read domain.
- Synchronizes the incoming Gray read pointer through a reset-to-zero flop chain.
- Generates full, occupancy count, and a sticky overflow flag.

Parameters:
ADDR_W, 4, memory address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
SYNC_STAGES, 2, flop stages in the read-pointer synchronizer (legal range 2..4).
AFULL_THRESH, 12, occupancy at or above which afull asserts (only with the optional feature).

Ports:
clk  in  1  write-domain clock.
rst  in  1  asynchronous, active-high reset.
winc  in  1  write request from the producer.
ovf_clr  in  1  synchronous clear of the overflow flag.
rptr_gray_async  in  ADDR_W+1  Gray read pointer from the read domain; not synchronous to clk.
wen  out  1  memory write enable; equals winc & ~full (combinational).
waddr  out  ADDR_W  memory write address = wbin[ADDR_W-1:0].
wptr_gray  out  ADDR_W+1  registered Gray write pointer, sent to the read domain.
full  out  1  registered full flag.
wcount  out  ADDR_W+1  occupancy seen from the write side = wbin - rbin_sync, mod 2**(ADDR_W+1).
overflow  out  1  sticky flag: a write was attempted while full.
afull  out  1  almost-full flag (optional feature only).

Behaviour:
- Reset (async assert, sync release): wbin=0, wptr_gray=0, all synchronizer stages=0, full=0, overflow=0, afull=0. Outputs: wcount=0, waddr=0, wen=0.
- Synchronizer: rq_gray = rptr_gray_async delayed SYNC_STAGES clk cycles; rbin_sync = gray2bin(rq_gray).
- Write (wen=1): same edge updates wbin <= wbin+1 and wptr_gray <= bin2gray(wbin+1). Memory samples data at waddr on that edge.
- Rejected write (winc=1, full=1): wen=0, pointers hold, overflow <= 1.
- Overflow clear: ovf_clr clears overflow on the next edge. If ovf_clr coincides with a rejected write, set wins: overflow stays 1.
- Full:
  - Registered every cycle: full <= (wgray_next == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]}).
  - wgray_next = bin2gray(wbin + wen).
  - Full asserts on the same edge as the write that fills the FIFO, so the next write is blocked in the following cycle.
- Full deassertion latency: a read-pointer change reaches full SYNC_STAGES+1 clk edges after it is stable at the input. full is therefore pessimistic, never optimistic.
- Wrap-around: pointers wrap 2**(ADDR_W+1)-1 -> 0. wcount uses modulo subtraction and remains correct across the wrap.
- wcount never exceeds 2**ADDR_W.
- Reset mid-operation: everything returns to reset values immediately; a pending wen drops with rst.
- Gray property: wptr_gray changes by exactly one bit per write.

Optional Feature:
FIFO_ALMOST_FULL_EN.
- Defined: afull is a registered flag, afull <= (wbin_next - rbin_sync) >= AFULL_THRESH. It has the same latency and pessimism as full. Reset value 0.
- Undefined: afull is tied to 0, and no comparator or register is built.

Decomposition:
- Package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized by width.
  - Default constants ADDR_W_DEF=4 and SYNC_STAGES_DEF=2.
  - Pointer typedef ptr_t = logic [ADDR_W_DEF:0].
- One sub-module, sync_chain: a SYNC_STAGES-deep, N-bit flop chain with async active-high reset to 0. It is reused by the matching read-side controller.

Test Plan:
All scenarios use defaults (depth 16), with rptr_gray_async held at 0 unless stated.
- Reset: assert rst mid-cycle -> wptr_gray=0, full=0, overflow=0, wcount=0 immediately, without waiting for a clk edge.
- Fill: 16 back-to-back winc -> waddr runs 0..15, and full=1 after the 16th edge. Check wptr_gray=5'b11000, wcount=16, and that each pointer step flips exactly one bit.
- Overflow: with full=1, winc=1 for 1 cycle -> wen=0, wptr_gray unchanged, overflow=1 and held. Then ovf_clr=1 -> overflow=0 next edge. Then ovf_clr=1 with winc=1 -> overflow stays 1.
- Read release: full FIFO, set rptr_gray_async=5'b00001 (one read) -> full=0 exactly 3 edges later, wcount=15.
- Wrap: 40 writes interleaved with matching rptr_gray_async advances -> pointer wraps 31->0, full never falsely asserts, and wcount matches the reference model every cycle.
- With FIFO_ALMOST_FULL_EN: 11 writes -> afull=0; 12th write -> afull=1 on that edge; one read synced -> afull=0 after 3 edges.
